// File: rtl/vga_pkg.sv
// Shared timing defaults, sequencer state encoding and a constant-width helper
// for the VGA screen sequencer.
package vga_pkg;

    localparam int PIX_DIV_DEF = 4;
    localparam int H_DISP_DEF  = 640;
    localparam int H_FP_DEF    = 16;
    localparam int H_SYNC_DEF  = 96;
    localparam int H_BP_DEF    = 48;
    localparam int V_DISP_DEF  = 480;
    localparam int V_FP_DEF    = 10;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BP_DEF    = 33;

    typedef enum logic [1:0] {
        ST_SHOW  = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2,
        ST_SWAP  = 2'd3
    } scr_state_e;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, pixel/line counters and registered sync generation.
// All outputs change together on the edge that advances the pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV = PIX_DIV_DEF,
    parameter int H_DISP  = H_DISP_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BP    = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = clog2(PIX_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             p_tick_q, p_tick_d;
    logic             frame_start_q, frame_start_d;
    logic             tick_en;

    always_comb begin
        tick_en = (div_q == DIV_W'(PIX_DIV - 1));
        div_d   = tick_en ? '0 : div_q + 1'b1;
        x_d     = x_q;
        y_d     = y_q;
        if (tick_en) begin
            if (x_q == 10'(H_TOTAL - 1)) begin
                x_d = '0;
                y_d = (y_q == 10'(V_TOTAL - 1)) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Syncs are decoded from the next count so they line up with pixel_x/y.
        hsync_d       = !((x_d >= 10'(H_DISP + H_FP)) && (x_d <= 10'(H_DISP + H_FP + H_SYNC - 1)));
        vsync_d       = !((y_d >= 10'(V_DISP + V_FP)) && (y_d <= 10'(V_DISP + V_FP + V_SYNC - 1)));
        p_tick_d      = tick_en;
        frame_start_d = tick_en && (x_d == 10'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            p_tick_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            p_tick_q      <= p_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign p_tick      = p_tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = (x_q < 10'(H_DISP)) && (y_q < 10'(V_DISP));

endmodule

// File: rtl/vga_screen_sequencer.sv
// VGA screen sequencer: selects one of NUM_SCREENS sources and switches between
// them only on frame boundaries, inserting BLANK_FRAMES black frames per switch.
module vga_screen_sequencer
    import vga_pkg::*;
#(
    parameter int NUM_SCREENS  = 3,
    parameter int RGB_W        = 3,
    parameter int ADDR_W       = 11,
    parameter int PIX_DIV      = PIX_DIV_DEF,
    parameter int H_DISP       = H_DISP_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_DISP       = V_DISP_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter int BLANK_FRAMES = 2
) (
    input  logic                          clk_100MHz,
    input  logic                          reset_n,
    input  logic [NUM_SCREENS-1:0]        scr_req,
    input  logic [NUM_SCREENS*RGB_W-1:0]  scr_rgb,
    input  logic [NUM_SCREENS*ADDR_W-1:0] scr_rom_addr,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          video_on,
    output logic                          p_tick,
    output logic [9:0]                    pixel_x,
    output logic [9:0]                    pixel_y,
    output logic                          frame_start,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic [RGB_W-1:0]              rgb,
    output logic [2:0]                    active_scr,
    output logic                          switching
);

    scr_state_e       state_q, state_d;
    logic [2:0]       target_q, target_d;
    logic [2:0]       active_q, active_d;
    logic [3:0]       blank_cnt_q, blank_cnt_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             req_hit;
    logic [2:0]       req_idx;
    logic [2:0]       src_idx;

    vga_timing_gen #(
        .PIX_DIV (PIX_DIV),
        .H_DISP  (H_DISP),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_DISP  (V_DISP),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk         (clk_100MHz),
        .rst_n       (reset_n),
        .p_tick      (p_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .frame_start (frame_start),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y)
    );

    // Lowest requested index other than the screen already on display.
    always_comb begin
        req_hit = 1'b0;
        req_idx = '0;
        for (int i = NUM_SCREENS - 1; i >= 0; i--) begin
            if (scr_req[i] && (int'(active_q) != i)) begin
                req_hit = 1'b1;
                req_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        active_d    = active_q;
        blank_cnt_d = blank_cnt_q;
        case (state_q)
            ST_SHOW: begin
                if (req_hit) begin
                    target_d = req_idx;
                    state_d  = ST_PEND;
                end
            end
            ST_PEND: begin
                if (req_hit) begin
                    target_d = req_idx;
                end
                if (frame_start) begin
                    state_d     = ST_BLANK;
                    blank_cnt_d = '0;
                end
            end
            ST_BLANK: begin
                if (req_hit) begin
                    target_d = req_idx;
                end
                if (frame_start) begin
                    if (blank_cnt_q == 4'(BLANK_FRAMES - 1)) begin
                        state_d = ST_SWAP;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 4'd1;
                    end
                end
            end
            ST_SWAP: begin
                active_d = target_q;
                state_d  = ST_SHOW;
            end
            default: state_d = ST_SHOW;
        endcase
    end

    // The first pixel after the last blank frame already belongs to the target.
    always_comb begin
        src_idx = (state_q == ST_BLANK) ? target_d : active_q;
        rgb_d   = rgb_q;
        if (p_tick) begin
            rgb_d = '0;
            if (video_on && (state_d != ST_BLANK)) begin
                for (int i = 0; i < NUM_SCREENS; i++) begin
                    if (int'(src_idx) == i) begin
                        rgb_d = scr_rgb[i*RGB_W +: RGB_W];
                    end
                end
            end
        end
    end

    always_comb begin
        rom_addr = scr_rom_addr[ADDR_W-1:0];
        for (int i = 0; i < NUM_SCREENS; i++) begin
            if (int'(active_q) == i) begin
                rom_addr = scr_rom_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SHOW;
            target_q    <= '0;
            active_q    <= '0;
            blank_cnt_q <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            active_q    <= active_d;
            blank_cnt_q <= blank_cnt_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign active_scr = active_q;
    assign switching  = (state_q != ST_SHOW);

endmodule

// File: tb/tb_vga_screen_sequencer.sv
// Bench for vga_screen_sequencer: small-timing instance against a frame-arithmetic
// reference model, plus a default-parameter instance for the 640x480 line timing.
module tb_vga_screen_sequencer;

    localparam int NS  = 3;
    localparam int RW  = 3;
    localparam int AW  = 11;
    localparam int PD  = 4;
    localparam int HD  = 8;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 2;
    localparam int VD  = 4;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int BF  = 2;
    localparam int HT  = HD + HF + HS + HB;
    localparam int VT  = VD + VF + VS + VB;
    localparam int FP  = HT * VT * PD;
    localparam int RWT = NS * RW;
    localparam int AWT = NS * AW;

    logic           clk;
    logic           reset_n;
    logic [NS-1:0]  scr_req;
    logic [RWT-1:0] scr_rgb;
    logic [AWT-1:0] scr_rom_addr;
    logic           hsync, vsync, video_on, p_tick, frame_start, switching;
    logic [9:0]     pixel_x, pixel_y;
    logic [AW-1:0]  rom_addr;
    logic [RW-1:0]  rgb;
    logic [2:0]     active_scr;

    logic           rstd_n;
    logic [2:0]     d_req;
    logic [8:0]     d_rgb_in;
    logic [32:0]    d_rom_in;
    logic           d_hsync, d_vsync, d_video_on, d_p_tick, d_frame_start, d_switching;
    logic [9:0]     d_pixel_x, d_pixel_y;
    logic [10:0]    d_rom_addr;
    logic [2:0]     d_rgb, d_active;

    int n_vec = 0;
    int n_err = 0;
    int k = 0;
    int m_active, m_tgt, m_c1, m_c2;
    bit m_sw;
    logic [RW-1:0] m_rgb;
    bit dflt_done = 1'b0;

    typedef struct {
        int         hold;
        logic [2:0] req;
        int         idle;
        int         exp_act;
        bit         exp_sw;
    } vec_t;
    vec_t tbl[11];

    vga_screen_sequencer #(
        .NUM_SCREENS(NS), .RGB_W(RW), .ADDR_W(AW), .PIX_DIV(PD),
        .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BLANK_FRAMES(BF)
    ) dut (
        .clk_100MHz(clk), .reset_n(reset_n), .scr_req(scr_req), .scr_rgb(scr_rgb),
        .scr_rom_addr(scr_rom_addr), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
        .rom_addr(rom_addr), .rgb(rgb), .active_scr(active_scr), .switching(switching)
    );

    vga_screen_sequencer dut_d (
        .clk_100MHz(clk), .reset_n(rstd_n), .scr_req(d_req), .scr_rgb(d_rgb_in),
        .scr_rom_addr(d_rom_in), .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
        .p_tick(d_p_tick), .pixel_x(d_pixel_x), .pixel_y(d_pixel_y), .frame_start(d_frame_start),
        .rom_addr(d_rom_addr), .rgb(d_rgb), .active_scr(d_active), .switching(d_switching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, k);
        end
    endtask

    function automatic void pos_at(input int kk, output int x, output int y, output bit tick);
        int n;
        n    = kk / PD;
        x    = n % HT;
        y    = (n / HT) % VT;
        tick = (kk > 0) && (kk % PD == 0);
    endfunction

    function automatic int lowest_other(input logic [NS-1:0] r, input int act);
        int res;
        res = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (r[i] && i != act) res = i;
        end
        return res;
    endfunction

    task automatic check_outputs();
        int x, y;
        bit tick, e_hs, e_vs, e_vid, e_fs;
        pos_at(k, x, y, tick);
        e_hs  = !(x >= HD + HF && x < HD + HF + HS);
        e_vs  = !(y >= VD + VF && y < VD + VF + VS);
        e_vid = (x < HD) && (y < VD);
        e_fs  = tick && (x == 0) && (y == 0);
        chk("p_tick", 32'(p_tick), 32'(tick));
        chk("pixel_x", 32'(pixel_x), 32'(x));
        chk("pixel_y", 32'(pixel_y), 32'(y));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("video_on", 32'(video_on), 32'(e_vid));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("rgb", 32'(rgb), 32'(m_rgb));
        chk("active_scr", 32'(active_scr), 32'(m_active));
        chk("switching", 32'(switching), 32'(m_sw));
        chk("rom_addr", 32'(rom_addr), 32'(scr_rom_addr[m_active*AW +: AW]));
    endtask

    // Advance the reference across one clock edge using the inputs now applied.
    task automatic model_edge();
        int x, y, lo, idx;
        bit tick;
        pos_at(k, x, y, tick);
        lo = lowest_other(scr_req, m_active);
        if (!m_sw) begin
            if (lo >= 0) begin
                m_sw  = 1'b1;
                m_tgt = lo;
                m_c1  = ((k + FP) / FP) * FP;
                m_c2  = m_c1 + BF * FP;
            end
        end else if (k <= m_c2) begin
            if (lo >= 0) m_tgt = lo;
        end
        if (tick) begin
            if (m_sw && k >= m_c1 && k < m_c2) begin
                m_rgb = '0;
            end else if (!(x < HD && y < VD)) begin
                m_rgb = '0;
            end else begin
                idx   = (m_sw && k == m_c2) ? m_tgt : m_active;
                m_rgb = scr_rgb[idx*RW +: RW];
            end
        end
        if (m_sw && k == m_c2 + 1) begin
            m_active = m_tgt;
            m_sw     = 1'b0;
        end
        k++;
    endtask

    task automatic step(input logic [NS-1:0] req);
        check_outputs();
        scr_req      = req;
        scr_rgb      = RWT'($urandom());
        scr_rom_addr = AWT'({$urandom(), $urandom()});
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        k        = 0;
        m_active = 0;
        m_tgt    = 0;
        m_sw     = 1'b0;
        m_c1     = 0;
        m_c2     = 0;
        m_rgb    = '0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pixel_x"}, 32'(pixel_x), 0);
        chk({tag, "_pixel_y"}, 32'(pixel_y), 0);
        chk({tag, "_hsync"}, 32'(hsync), 1);
        chk({tag, "_vsync"}, 32'(vsync), 1);
        chk({tag, "_rgb"}, 32'(rgb), 0);
        chk({tag, "_p_tick"}, 32'(p_tick), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_active"}, 32'(active_scr), 0);
        chk({tag, "_switching"}, 32'(switching), 0);
    endtask

    // Default-parameter instance: 640x480 line timing.
    initial begin : dflt_chk
        int t1, t2, hs_x, hs_ticks, max_x, y_after, prev_x;
        bit in_low, low_done, wrapped;
        t1 = -1; t2 = -1; hs_x = -1; hs_ticks = 0; max_x = 0; y_after = -1; prev_x = 0;
        in_low = 1'b0; low_done = 1'b0; wrapped = 1'b0;
        d_req = '0; d_rgb_in = 9'h1a5; d_rom_in = '0;
        rstd_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstd_n = 1'b1;
        for (int t = 1; t <= 7000; t++) begin
            @(negedge clk);
            if (d_p_tick) begin
                if (t1 < 0) t1 = t;
                else if (t2 < 0) t2 = t;
            end
            if (!d_hsync && !low_done) begin
                if (!in_low) begin
                    in_low = 1'b1;
                    hs_x   = int'(d_pixel_x);
                end
                if (d_p_tick) hs_ticks++;
            end else if (in_low) begin
                in_low   = 1'b0;
                low_done = 1'b1;
            end
            if (int'(d_pixel_x) > max_x) max_x = int'(d_pixel_x);
            if (!wrapped && prev_x == 799 && d_pixel_x == 10'd0) begin
                wrapped = 1'b1;
                y_after = int'(d_pixel_y);
            end
            prev_x = int'(d_pixel_x);
        end
        chk("dflt_first_tick", 32'(t1), 4);
        chk("dflt_tick_period", 32'(t2 - t1), 4);
        chk("dflt_hsync_start_x", 32'(hs_x), 656);
        chk("dflt_hsync_ticks", 32'(hs_ticks), 96);
        chk("dflt_max_x", 32'(max_x), 799);
        chk("dflt_y_after_wrap", 32'(y_after), 1);
        dflt_done = 1'b1;
    end

    initial begin : main
        logic [NS-1:0] r;
        tbl[0]  = '{10, 3'b001,   90, 0, 1'b0};
        tbl[1]  = '{ 1, 3'b010,   19, 0, 1'b1};
        tbl[2]  = '{ 0, 3'b000, 1321, 0, 1'b1};
        tbl[3]  = '{ 0, 3'b000,    1, 1, 1'b0};
        tbl[4]  = '{ 1, 3'b001, 1439, 0, 1'b0};
        tbl[5]  = '{ 1, 3'b110, 1438, 0, 1'b1};
        tbl[6]  = '{ 0, 3'b000,    1, 1, 1'b0};
        tbl[7]  = '{ 1, 3'b001, 1439, 0, 1'b0};
        tbl[8]  = '{ 1, 3'b010,  737, 0, 1'b1};
        tbl[9]  = '{ 1, 3'b100,  700, 0, 1'b1};
        tbl[10] = '{ 0, 3'b000,    1, 2, 1'b0};

        reset_n      = 1'b0;
        scr_req      = '0;
        scr_rgb      = RWT'($urandom());
        scr_rom_addr = AWT'({$urandom(), $urandom()});
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values("rst");
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            for (int h = 0; h < tbl[i].hold; h++) step(tbl[i].req);
            for (int d = 0; d < tbl[i].idle; d++) step('0);
            chk($sformatf("tbl%0d_active", i), 32'(active_scr), 32'(tbl[i].exp_act));
            chk($sformatf("tbl%0d_switching", i), 32'(switching), 32'(tbl[i].exp_sw));
        end

        // Reset dropped in the middle of a blanking period.
        step(3'b001);
        for (int d = 0; d < 797; d++) step('0);
        chk("midblank_switching", 32'(switching), 1);
        chk("midblank_rgb", 32'(rgb), 0);
        #1 reset_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                r = NS'($urandom_range(1, 7));
                if (r[m_active]) r = NS'(1) << m_active;
                step(r);
            end else begin
                step('0);
            end
        end

        chk("dflt_done", 32'(dflt_done), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_screen_sequencer.md
VGA_SCREEN_SEQUENCER -- requirements
Module: vga_screen_sequencer

Interface
REQ-001 SHALL have parameter NUM_SCREENS, default 3, number of screen sources (2..8); screen 0 is the start screen.
REQ-002 SHALL have parameter RGB_W, default 3, per-pixel colour width.
REQ-003 SHALL have parameter ADDR_W, default 11, font-ROM address width.
REQ-004 SHALL have parameter PIX_DIV, default 4, clk_100MHz cycles per pixel (integer 2..16).
REQ-005 SHALL have parameters H_DISP/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, and V_DISP/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, giving timing in pixels and lines.
REQ-006 SHALL have parameter BLANK_FRAMES, default 2, the number of black frames inserted on a screen switch (1..15).
REQ-007 SHALL have ports, in this order:
- clk_100MHz  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- scr_req  in  NUM_SCREENS  level switch request; bit i selects screen i.
- scr_rgb  in  NUM_SCREENS*RGB_W  packed per-screen colour, screen i at [i*RGB_W +: RGB_W].
- scr_rom_addr  in  NUM_SCREENS*ADDR_W  packed per-screen ROM address.
- hsync, vsync  out  1  active-low syncs.
- video_on  out  1  high inside the visible region.
- p_tick  out  1  one-cycle pixel strobe.
- pixel_x, pixel_y  out  10  current counters.
- frame_start  out  1  one-cycle pulse at pixel (0,0).
- rom_addr  out  ADDR_W  address of the active screen.
- rgb  out  RGB_W  registered colour.
- active_scr  out  3  index of the screen being shown.
- switching  out  1  high while a switch is in progress.

Function
REQ-008 SHALL assert p_tick for one cycle every PIX_DIV clocks, driven by a free-running divider.
REQ-009 SHALL advance pixel_x on p_tick, wrapping at H_DISP+H_FP+H_SYNC+H_BP-1 to 0; on that wrap, pixel_y SHALL advance and wrap at its vertical total minus 1.
REQ-010 SHALL drive hsync low for pixel_x in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1], with vsync defined the same way on pixel_y; both outputs SHALL be registered.
REQ-011 SHALL drive video_on = (pixel_x<H_DISP)&&(pixel_y<V_DISP).
REQ-012 SHALL pulse frame_start for one cycle on the p_tick at which both counters wrap to (0,0).
REQ-013 SHALL implement FSM states SHOW, PEND, BLANK and SWAP.
REQ-014 In SHOW, a scr_req bit set for a screen other than active_scr SHALL latch target = the lowest set index and move the FSM to PEND; a request for the active screen only SHALL be ignored.
REQ-015 In PEND, the FSM SHALL move to BLANK on frame_start, so no frame tears.
REQ-016 In BLANK, the FSM SHALL count frame_start pulses; after BLANK_FRAMES pulses it SHALL go to SWAP.
REQ-017 In PEND or BLANK, a new differing request SHALL overwrite target without restarting the blank count.
REQ-018 SWAP SHALL last one cycle, load active_scr=target, and return to SHOW.
REQ-019 switching SHALL be high in PEND, BLANK and SWAP.
REQ-020 rom_addr SHALL combinationally select the scr_rom_addr slice given by active_scr.
REQ-021 rgb SHALL register, one clock after p_tick, the scr_rgb slice for active_scr, and SHALL be 0 when video_on is low or the FSM is in BLANK.
REQ-022 Out-of-range target indices are unreachable, because only requests for valid indices are latched.

Reset
REQ-023 While reset_n is low, outputs SHALL be: counters 0, divider 0, hsync=vsync=1, rgb=0, p_tick=0, frame_start=0, active_scr=0, switching=0, FSM=SHOW.
REQ-024 A reset mid-switch SHALL abandon the pending target and show screen 0.
REQ-025 After reset_n rises, the first p_tick SHALL occur PIX_DIV clocks later.

Structure
REQ-026 The timing defaults, FSM state encoding and the CLOG2 helper SHALL live in the shared package vga_pkg.
REQ-027 Sync and counter generation SHALL be the sub-module vga_timing_gen; the FSM and the muxes SHALL stay at top level.

Verification
REQ-028 After reset with defaults: p_tick period = 4 clocks; hsync low for 96 ticks starting at pixel_x=656; 800x525 totals are reached.
REQ-029 In SHOW with screen 0, setting scr_req=3'b010 mid-frame: switching rises; rgb=0 for exactly 2 frames starting at the next frame_start; active_scr=1 one cycle after the second blank frame ends.
REQ-030 Setting scr_req=3'b110: target=1 (lowest index wins).
REQ-031 Setting scr_req=3'b100 during the first blank frame while the target is 1: active_scr=2 after the same 2-frame total.
REQ-032 Setting scr_req=3'b001 while on screen 0: no state change, and switching stays 0.
REQ-033 Dropping reset_n during BLANK: outputs take reset values asynchronously; after release, active_scr=0 and rgb tracks screen 0.
